// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx arbiter slice.
//   - baud_sel codes understood by uart_tx (0 = 9600 .. 4 = 115200)
//   - arbiter state encoding
package uart_tx_arb_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per source
//   ptr : highest-priority index this round (must be < N)
//   idx : first requesting index at or after ptr, wrapping mod N
//   any : at least one request present
// Shared with the rx-side dispatcher, so kept free of arbiter state.
module uart_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Outer loop walks priority order ptr, ptr+1, ...; inner loop maps the
  // wrapped position back to a constant index so no variable select is needed.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!any && req[j] && ((32'(ptr) + i) % N) == j) begin
          any = 1'b1;
          idx = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one uart_tx among N_SRC sources.
//   clk, rst_n      : 50MHz clock, asynchronous active-low reset
//   src_valid/data/last/ready : per-source byte streams (data is 8 bits each)
//   cfg_baud_sel    : requested baud code, sampled only while idle
//   baud_sel        : baud code to uart_tx, frozen for a whole packet
//   tx_data, tx_req : byte and frame-start request to uart_tx
//   tx_busy, tx_end : uart_tx status and end-of-frame pulse
//   gnt_vld, gnt_id : active packet grant and its source index
//   pkt_done        : 1-cycle pulse, packet finished normally
//   tmo_err         : 1-cycle pulse, packet aborted by inter-byte timeout
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TMO_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]     src_last,
  output logic [N_SRC-1:0]     src_ready,
  input  logic [2:0]           cfg_baud_sel,
  output logic [2:0]           baud_sel,
  output logic [7:0]           tx_data,
  output logic                 tx_req,
  input  logic                 tx_busy,
  input  logic                 tx_end,
  output logic                 gnt_vld,
  output logic [IDX_W-1:0]     gnt_id,
  output logic                 pkt_done,
  output logic                 tmo_err
);

  localparam int unsigned      TMO_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TMO_W-1:0]  tmo;
  logic              last_r;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [IDX_W-1:0]  nxt_ptr;
  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;

  uart_rr_pick #(
    .N (N_SRC),
    .W (IDX_W)
  ) u_pick (
    .req (src_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The served source drops to lowest priority next round.
  always_comb begin
    nxt_ptr = gnt_id + 1'b1;
    if (32'(gnt_id) + 1 >= N_SRC) nxt_ptr = '0;
  end

  // Granted-source mux and one-hot ready; other sources are never looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    src_ready = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (32'(gnt_id) == i) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[8*i +: 8];
        if (state == S_FETCH) src_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_sel <= BAUD_9600;
      tx_data  <= '0;
      tx_req   <= 1'b0;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      pkt_done <= 1'b0;
      tmo_err  <= 1'b0;
      rr_ptr   <= '0;
      tmo      <= '0;
      last_r   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      tmo_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_sel <= cfg_baud_sel;
          tmo      <= '0;
          if (pick_any) begin
            gnt_id  <= pick_idx;
            gnt_vld <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            last_r  <= sel_last;
            tmo     <= '0;
            tx_req  <= 1'b1;
            state   <= S_REQ;
          end else if (tmo == TMO_LAST) begin
            tmo_err <= 1'b1;
            gnt_vld <= 1'b0;
            rr_ptr  <= nxt_ptr;
            tmo     <= '0;
            state   <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        // tx_req stays up until busy is seen; uart_tx ignores the overlap cycle.
        S_REQ: begin
          if (tx_busy) begin
            tx_req <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_end) begin
            if (last_r) begin
              pkt_done <= 1'b1;
              gnt_vld  <= 1'b0;
              rr_ptr   <= nxt_ptr;
              state    <= S_IDLE;
            end else begin
              tmo   <= '0;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural uart_tx
// (16 cycles/bit, 10-bit frame) and TMO_CYC = 64.
module tb_uart_tx_arb;

  localparam int unsigned N         = 4;
  localparam int unsigned W         = 2;
  localparam int unsigned TMO       = 64;
  localparam int unsigned BIT_CYC   = 16;
  localparam int unsigned FRAME_CYC = 10 * BIT_CYC;

  typedef struct packed {
    logic [7:0]   data;
    logic [W-1:0] id;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [8*N-1:0] src_data;
  logic [2:0]     cfg_baud_sel, baud_sel;
  logic [7:0]     tx_data;
  logic           tx_req, tx_busy, tx_end, gnt_vld, pkt_done, tmo_err;
  logic [W-1:0]   gnt_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.N_SRC(N), .IDX_W(W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .cfg_baud_sel(cfg_baud_sel), .baud_sel(baud_sel),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy), .tx_end(tx_end),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id), .pkt_done(pkt_done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural uart_tx ----------------
  int unsigned ucnt;
  logic [7:0]  ubyte;
  logic        line;
  logic [7:0]  lsh;
  frame_t      frames[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      ucnt    <= 0;
      ubyte   <= '0;
    end else if (!tx_busy) begin
      if (tx_req) begin
        frame_t f;
        f.data = tx_data;
        f.id   = gnt_id;
        frames.push_back(f);
        tx_busy <= 1'b1;
        ucnt    <= 0;
        ubyte   <= tx_data;
      end
    end else if (ucnt == FRAME_CYC - 1) begin
      tx_busy <= 1'b0;
    end else begin
      ucnt <= ucnt + 1;
    end
  end

  assign tx_end = tx_busy && (ucnt == FRAME_CYC - 1);

  always_comb begin
    line = 1'b1;
    lsh  = '0;
    if (tx_busy) begin
      if (ucnt < BIT_CYC) line = 1'b0;
      else if (ucnt < 9 * BIT_CYC) begin
        lsh  = ubyte >> (ucnt / BIT_CYC - 1);
        line = lsh[0];
      end
    end
  end

  // ---------------- monitors ----------------
  int unsigned cyc = 0;
  int unsigned end_cyc[$], req_cyc[$], tmo_cyc[$];
  int done_cnt = 0, tmo_cnt = 0, stab_bad = 0, rdy_bad = 0, baud_bad = 0;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  logic [2:0] prev_baud = '0;

  always @(negedge clk) begin
    cyc++;
    if (tx_end) end_cyc.push_back(cyc);
    if (tx_req && !prev_req) req_cyc.push_back(cyc);
    prev_req = tx_req;
    if (pkt_done) done_cnt++;
    if (tmo_err) begin tmo_cnt++; tmo_cyc.push_back(cyc); end
    if (tx_busy && tx_data !== ubyte) stab_bad++;
    if (src_ready !== '0 && src_ready !== (N'(1) << gnt_id)) rdy_bad++;
    if (gnt_vld && prev_gnt && baud_sel !== prev_baud) baud_bad++;
    prev_gnt  = gnt_vld;
    prev_baud = baud_sel;
  end

  // ---------------- source driver ----------------
  logic [8:0] sq[N][$];   // {last, data}

  initial begin
    logic [N-1:0] hs;
    forever begin
      for (int i = 0; i < N; i++) begin
        src_valid[i] = (sq[i].size() > 0);
        if (sq[i].size() > 0) begin
          src_data[8*i +: 8] = sq[i][0][7:0];
          src_last[i]        = sq[i][0][8];
        end else begin
          src_data[8*i +: 8] = 8'($urandom);
          src_last[i]        = 1'($urandom);
        end
      end
      @(posedge clk);
      hs = src_valid & src_ready;
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) void'(sq[i].pop_front());
    end
  end

  // ---------------- helpers (stimulus/bookkeeping only) ----------------
  task automatic clear_state();
    for (int i = 0; i < N; i++) sq[i].delete();
    frames.delete(); end_cyc.delete(); req_cyc.delete(); tmo_cyc.delete();
    done_cnt = 0; tmo_cnt = 0; stab_bad = 0; rdy_bad = 0; baud_bad = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_state();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic last);
    sq[s].push_back({last, d});
  endtask

  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt + tmo_cnt >= n) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cfg_baud_sel = 3'd3;
    repeat (3) @(negedge clk);
    checks++; if (tx_req !== 1'b0)   begin errors++; $display("FAIL reset_tx_req: got %0h want 0", tx_req); end
    checks++; if (gnt_vld !== 1'b0)  begin errors++; $display("FAIL reset_gnt_vld: got %0h want 0", gnt_vld); end
    checks++; if (gnt_id !== '0)     begin errors++; $display("FAIL reset_gnt_id: got %0h want 0", gnt_id); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %0h want 0", pkt_done); end
    checks++; if (tmo_err !== 1'b0)  begin errors++; $display("FAIL reset_tmo_err: got %0h want 0", tmo_err); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
    checks++; if (baud_sel !== 3'd0) begin errors++; $display("FAIL reset_baud_sel: got %0h want 0", baud_sel); end
    checks++; if (src_ready !== '0)  begin errors++; $display("FAIL reset_src_ready: got %0h want 0", src_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (baud_sel !== 3'd3) begin errors++; $display("FAIL idle_baud_track: got %0h want 3", baud_sel); end
    cfg_baud_sel = 3'd0;
  endtask

  task automatic test_single_packet();
    bit ok;
    logic [7:0] exp[3] = '{8'h55, 8'hA3, 8'h0F};
    do_reset();
    push_byte(1, 8'h55, 1'b0);
    push_byte(1, 8'hA3, 1'b0);
    push_byte(1, 8'h0F, 1'b1);
    wait_events(1, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait: got timeout want pkt_done"); end
    checks++; if (frames.size() != 3) begin errors++; $display("FAIL single_nframes: got %0d want 3", frames.size()); end
    for (int i = 0; i < 3 && i < frames.size(); i++) begin
      checks++; if (frames[i].data !== exp[i]) begin errors++; $display("FAIL single_data[%0d]: got %0h want %0h", i, frames[i].data, exp[i]); end
      checks++; if (frames[i].id !== 2'd1) begin errors++; $display("FAIL single_id[%0d]: got %0d want 1", i, frames[i].id); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL single_tmo_cnt: got %0d want 0", tmo_cnt); end
    for (int i = 1; i < 3; i++) begin
      if (req_cyc.size() > i && end_cyc.size() >= i) begin
        checks++; if (req_cyc[i] - end_cyc[i-1] != 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 2", i, req_cyc[i] - end_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    logic [W-1:0] exp_id[4] = '{2'd0, 2'd2, 2'd3, 2'd0};
    logic [7:0]   exp_d[4]  = '{8'hA0, 8'hB2, 8'hC3, 8'hA1};
    do_reset();
    push_byte(0, 8'hA0, 1'b1);
    push_byte(0, 8'hA1, 1'b1);
    push_byte(2, 8'hB2, 1'b1);
    push_byte(3, 8'hC3, 1'b1);
    wait_events(4, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_wait: got timeout want 4 packets"); end
    checks++; if (frames.size() != 4) begin errors++; $display("FAIL rr_nframes: got %0d want 4", frames.size()); end
    for (int i = 0; i < 4 && i < frames.size(); i++) begin
      checks++; if (frames[i].id !== exp_id[i] || frames[i].data !== exp_d[i]) begin
        errors++; $display("FAIL rr_frame[%0d]: got id %0d data %0h want id %0d data %0h", i, frames[i].id, frames[i].data, exp_id[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    push_byte(2, 8'h11, 1'b0);
    push_byte(3, 8'h33, 1'b1);
    wait_events(2, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_wait: got timeout want tmo_err+pkt_done"); end
    checks++; if (tmo_cnt != 1) begin errors++; $display("FAIL tmo_cnt: got %0d want 1", tmo_cnt); end
    if (tmo_cyc.size() > 0 && end_cyc.size() > 0) begin
      checks++; if (tmo_cyc[0] - end_cyc[0] != TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", tmo_cyc[0] - end_cyc[0], TMO + 1); end
    end
    checks++; if (frames.size() != 2) begin errors++; $display("FAIL tmo_nframes: got %0d want 2", frames.size()); end
    if (frames.size() == 2) begin
      checks++; if (frames[0].id !== 2'd2 || frames[0].data !== 8'h11) begin errors++; $display("FAIL tmo_frame0: got id %0d data %0h want id 2 data 11", frames[0].id, frames[0].data); end
      checks++; if (frames[1].id !== 2'd3 || frames[1].data !== 8'h33) begin errors++; $display("FAIL tmo_frame1: got id %0d data %0h want id 3 data 33", frames[1].id, frames[1].data); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_baud_hold();
    bit ok;
    int bad = 0;
    do_reset();
    cfg_baud_sel = 3'd0;
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b0);
    push_byte(0, 8'h03, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (gnt_vld) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL baud_grant_wait: got timeout want gnt_vld"); end
    cfg_baud_sel = 3'd4;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (gnt_vld && baud_sel !== 3'd0) bad++;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL baud_done_wait: got timeout want pkt_done"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL baud_during_pkt: got %0d bad cycles want 0", bad); end
    repeat (2) @(negedge clk);
    checks++; if (baud_sel !== 3'd4) begin errors++; $display("FAIL baud_after_pkt: got %0d want 4", baud_sel); end
    cfg_baud_sel = 3'd0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    push_byte(1, 8'h5A, 1'b0);
    push_byte(1, 8'h96, 1'b0);
    push_byte(1, 8'h3C, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin @(negedge clk); if (frames.size() >= 2) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait: got timeout want frame 2"); end
    repeat (3 * BIT_CYC) @(negedge clk);
    rst_n = 1'b0;
    clear_state();
    #2;
    checks++; if (tx_req !== 1'b0)  begin errors++; $display("FAIL rstmid_tx_req: got %0h want 0", tx_req); end
    checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL rstmid_gnt_vld: got %0h want 0", gnt_vld); end
    @(negedge clk);
    checks++; if (line !== 1'b1)    begin errors++; $display("FAIL rstmid_line: got %0h want 1", line); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(2, 8'hE7, 1'b0);
    push_byte(2, 8'h18, 1'b1);
    wait_events(1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_after_wait: got timeout want pkt_done"); end
    checks++; if (frames.size() != 2) begin errors++; $display("FAIL rstmid_nframes: got %0d want 2", frames.size()); end
    if (frames.size() == 2) begin
      checks++; if (frames[0].data !== 8'hE7 || frames[1].data !== 8'h18 || frames[0].id !== 2'd2 || frames[1].id !== 2'd2) begin
        errors++; $display("FAIL rstmid_frames: got %0h/%0d %0h/%0d want e7/2 18/2", frames[0].data, frames[0].id, frames[1].data, frames[1].id);
      end
    end
  endtask

  task automatic test_hold_unselected();
    bit ok;
    int bad_data = 0, bad_rdy = 0;
    do_reset();
    push_byte(1, 8'hC3, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (gnt_vld && gnt_id == 2'd1) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL hold_grant_wait: got timeout want grant 1"); end
    push_byte(0, 8'h0D, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (tx_req) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL hold_req_wait: got timeout want tx_req"); end
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (tx_data !== 8'hC3) bad_data++;
      if (src_ready[0] !== 1'b0) bad_rdy++;
      if (tx_end) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL hold_end_wait: got timeout want tx_end"); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL hold_tx_data: got %0d bad cycles want 0", bad_data); end
    checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL hold_src_ready0: got %0d bad cycles want 0", bad_rdy); end
    wait_events(2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_done_wait: got timeout want 2 packets"); end
    checks++; if (frames.size() != 2 || (frames.size() == 2 && (frames[1].id !== 2'd0 || frames[1].data !== 8'h0D))) begin
      errors++; $display("FAIL hold_src0_served: got %0d frames want 2 ending 0d from src 0", frames.size());
    end
  endtask

  task automatic test_random(input int iter);
    bit ok;
    int npkt, nbytes;
    logic [8:0] mq[N][$];
    logic [8:0] b;
    frame_t exp_q[$];
    frame_t f;
    int unsigned ptr;
    do_reset();
    npkt = 0; nbytes = 0;
    for (int s = 0; s < N; s++) begin
      int np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        int len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) push_byte(s, 8'($urandom), k == len - 1);
        npkt++; nbytes += len;
      end
    end
    if (npkt == 0) begin push_byte($urandom_range(0, N - 1), 8'($urandom), 1'b1); npkt = 1; nbytes = 1; end
    // Reference: whole packets handed out in rotating priority, starting at 0.
    for (int s = 0; s < N; s++) mq[s] = sq[s];
    ptr = 0;
    while (1) begin
      bit found = 1'b0;
      int unsigned s = 0;
      for (int unsigned k = 0; k < N; k++)
        if (!found && mq[(ptr + k) % N].size() > 0) begin found = 1'b1; s = (ptr + k) % N; end
      if (!found) break;
      do begin
        b = mq[s].pop_front();
        f.data = b[7:0];
        f.id   = W'(s);
        exp_q.push_back(f);
      end while (!b[8]);
      ptr = (s + 1) % N;
    end
    ok = 1'b0;
    for (int k = 0; k < nbytes * 200 + 500; k++) begin
      @(negedge clk);
      if (k % 37 == 0) cfg_baud_sel = 3'($urandom_range(0, 4));
      if (done_cnt + tmo_cnt >= npkt) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL rand%0d_wait: got timeout want %0d packets", iter, npkt); end
    checks++; if (frames.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_nframes: got %0d want %0d", iter, frames.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
      checks++; if (frames[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand%0d_frame[%0d]: got id %0d data %0h want id %0d data %0h", iter, i, frames[i].id, frames[i].data, exp_q[i].id, exp_q[i].data);
      end
    end
    checks++; if (done_cnt != npkt) begin errors++; $display("FAIL rand%0d_done_cnt: got %0d want %0d", iter, done_cnt, npkt); end
    checks++; if (tmo_cnt != 0)     begin errors++; $display("FAIL rand%0d_tmo_cnt: got %0d want 0", iter, tmo_cnt); end
    checks++; if (stab_bad != 0)    begin errors++; $display("FAIL rand%0d_tx_data_stable: got %0d bad cycles want 0", iter, stab_bad); end
    checks++; if (rdy_bad != 0)     begin errors++; $display("FAIL rand%0d_ready_onehot: got %0d bad cycles want 0", iter, rdy_bad); end
    checks++; if (baud_bad != 0)    begin errors++; $display("FAIL rand%0d_baud_stable: got %0d bad cycles want 0", iter, baud_bad); end
    cfg_baud_sel = 3'd0;
  endtask

  initial begin
    cfg_baud_sel = 3'd0;
    test_reset();
    test_single_packet();
    test_rr_order();
    test_timeout();
    test_baud_hold();
    test_reset_mid_frame();
    test_hold_unselected();
    for (int it = 0; it < 3; it++) test_random(it);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
